// File: rtl/sr_cmd_sequencer_pkg.sv
// Shared types and decode helpers for the SR latch command sequencer.
// State and command codes are fixed so they can be read directly off a waveform.
package sr_cmd_sequencer_pkg;

    localparam int unsigned CntW = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StPulse = 3'd2,
        StHold  = 3'd3,
        StGap   = 3'd4
    } state_e;

    typedef enum logic {
        CmdSet = 1'b0,
        CmdRst = 1'b1
    } cmd_e;

    typedef struct packed {
        logic s;
        logic r;
        logic enable;
        logic busy;
    } drive_t;

    // Latch drive levels for the cycle spent in a given state.
    function automatic drive_t decode_drive(state_e st, cmd_e cmd);
        drive_t d;
        d = '0;
        case (st)
            StSetup, StHold: begin
                d.s    = (cmd == CmdSet);
                d.r    = (cmd == CmdRst);
                d.busy = 1'b1;
            end
            StPulse: begin
                d.s      = (cmd == CmdSet);
                d.r      = (cmd == CmdRst);
                d.enable = 1'b1;
                d.busy   = 1'b1;
            end
            StGap:   d.busy = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

    // Counter value loaded on entry to a state; the state ends when it reads zero.
    function automatic logic [CntW-1:0] cnt_reload(state_e st, int unsigned pulse_w,
                                                   int unsigned gap_w);
        logic [CntW-1:0] v;
        v = '0;
        case (st)
            StPulse: v = CntW'(pulse_w - 1);
            StGap:   v = CntW'(gap_w - 1);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Request and latch-drive bundle between a requester (master) and the sequencer (slave).
interface sr_cmd_sequencer_if;
    logic set_req;
    logic clr_req;
    logic S;
    logic R;
    logic Enable;
    logic busy;
    logic done;
    logic err_conflict;
    logic overrun;

    modport master (
        output set_req, clr_req,
        input  S, R, Enable, busy, done, err_conflict, overrun
    );

    modport slave (
        input  set_req, clr_req,
        output S, R, Enable, busy, done, err_conflict, overrun
    );
endinterface

// File: rtl/rise_edge_det.sv
// One-bit rising-edge detector; history resets to 1 so a level held through reset
// must drop before it can fire.
module rise_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);
    logic r_hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= i_d;
        end
    end

    assign o_rise = i_d & ~r_hist;
endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns set/clear request edges into non-overlapping S/R/Enable command pulses for a
// gated SR latch, with a one-deep pending slot for requests that arrive while busy.
module sr_cmd_sequencer
    import sr_cmd_sequencer_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    sr_cmd_sequencer_if.slave   bus
);
    logic   w_set_rise;
    logic   w_clr_rise;
    logic   w_conflict;
    logic   w_one;
    cmd_e   w_req_cmd;

    state_e          r_state,    w_state_nxt;
    cmd_e            r_cmd,      w_cmd_nxt;
    logic [CntW-1:0] r_cnt,      w_cnt_nxt;
    logic            r_pend_vld, w_pend_vld_nxt;
    cmd_e            r_pend_cmd, w_pend_cmd_nxt;
    logic            w_exit;
    logic            w_ovr_nxt;
    drive_t          w_drive_nxt;

    logic r_s;
    logic r_r;
    logic r_en;
    logic r_busy;
    logic r_done;
    logic r_err;
    logic r_ovr;

    rise_edge_det u_set_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_d    (bus.set_req),
        .o_rise (w_set_rise)
    );

    rise_edge_det u_clr_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_d    (bus.clr_req),
        .o_rise (w_clr_rise)
    );

    // Simultaneous edges are rejected outright; only a lone edge counts as a request.
    assign w_conflict = w_set_rise & w_clr_rise;
    assign w_one      = w_set_rise ^ w_clr_rise;
    assign w_req_cmd  = w_clr_rise ? CmdRst : CmdSet;

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_nxt      = r_cmd;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_cmd_nxt = r_pend_cmd;
        w_ovr_nxt      = 1'b0;
        w_exit         = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_one) begin
                    w_state_nxt = StSetup;
                    w_cmd_nxt   = w_req_cmd;
                end
            end
            StSetup: w_state_nxt = StPulse;
            StPulse: begin
                if (r_cnt == '0) begin
                    w_state_nxt = StHold;
                end
            end
            StHold: begin
                if (GAP_W == 0) begin
                    w_exit = 1'b1;
                end else begin
                    w_state_nxt = StGap;
                end
            end
            StGap: begin
                if (r_cnt == '0) begin
                    w_exit = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_exit) begin
            // Pending work wins; a same-edge request then refills the freed slot.
            if (r_pend_vld) begin
                w_state_nxt    = StSetup;
                w_cmd_nxt      = r_pend_cmd;
                w_pend_vld_nxt = w_one;
                if (w_one) begin
                    w_pend_cmd_nxt = w_req_cmd;
                end
            end else if (w_one) begin
                w_state_nxt = StSetup;
                w_cmd_nxt   = w_req_cmd;
            end else begin
                w_state_nxt = StIdle;
            end
        end else if (r_state != StIdle && w_one) begin
            w_ovr_nxt      = r_pend_vld;
            w_pend_vld_nxt = 1'b1;
            w_pend_cmd_nxt = w_req_cmd;
        end

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = cnt_reload(w_state_nxt, PULSE_W, GAP_W);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end else begin
            w_cnt_nxt = r_cnt;
        end

        w_drive_nxt = decode_drive(w_state_nxt, w_cmd_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cmd      <= CmdSet;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            r_pend_cmd <= CmdSet;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd      <= w_cmd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_cmd <= w_pend_cmd_nxt;
            r_s        <= w_drive_nxt.s;
            r_r        <= w_drive_nxt.r;
            r_en       <= w_drive_nxt.enable;
            r_busy     <= w_drive_nxt.busy;
            r_done     <= (r_state == StHold);
            r_err      <= w_conflict;
            r_ovr      <= w_ovr_nxt;
        end
    end

    assign bus.S            = r_s;
    assign bus.R            = r_r;
    assign bus.Enable       = r_en;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err_conflict = r_err;
    assign bus.overrun      = r_ovr;
endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench: two sequencers (with and without a guard gap) share random and
// directed request stimulus and are compared against a command-timeline model.
module tb_sr_cmd_sequencer;
    localparam int PW  = 2;
    localparam int GW0 = 4;
    localparam int GW1 = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;

    always #5 clk = ~clk;

    sr_cmd_sequencer_if bus0 ();
    sr_cmd_sequencer_if bus1 ();

    assign bus0.set_req = set_req;
    assign bus0.clr_req = clr_req;
    assign bus1.set_req = set_req;
    assign bus1.clr_req = clr_req;

    sr_cmd_sequencer #(.PULSE_W(PW), .GAP_W(GW0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sr_cmd_sequencer #(.PULSE_W(PW), .GAP_W(GW1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // Expected {S, R, Enable, busy, done, err_conflict, overrun} per cycle.
    logic [6:0] exp_q0[$];
    logic [6:0] exp_q1[$];

    bit m_pset = 1'b1;
    bit m_pclr = 1'b1;
    bit m_active[2];
    bit m_cmd[2];
    bit m_pvld[2];
    bit m_pcmd[2];
    int m_start[2];
    int m_done_at[2];
    bit m_prev_en[2];
    bit [1:0] m_prev_sr[2];

    function automatic int gap_of(input int d);
        return (d == 0) ? GW0 : GW1;
    endfunction

    // A command started at edge n occupies cycles n+1 .. n+PW+2+gap.
    task automatic start_cmd(input int d, input bit c);
        m_active[d]  = 1'b1;
        m_cmd[d]     = c;
        m_start[d]   = ncyc + 1;
        m_done_at[d] = ncyc + 1 + PW + 2;
    endtask

    task automatic model_step();
        bit se, ce, one, typ, ovr, dn, sr, en, bsy;
        int len, o, o2;
        logic [6:0] v;
        ncyc++;
        se  = set_req && !m_pset;
        ce  = clr_req && !m_pclr;
        one = se ^ ce;
        typ = ce;
        for (int d = 0; d < 2; d++) begin
            ovr = 1'b0;
            if (rst) begin
                m_active[d]  = 1'b0;
                m_pvld[d]    = 1'b0;
                m_done_at[d] = -1;
                v = '0;
            end else begin
                len = PW + 2 + gap_of(d);
                dn  = (m_done_at[d] == ncyc + 1);
                if (m_active[d]) begin
                    o = ncyc - m_start[d];
                    if (o == len - 1) begin
                        if (m_pvld[d]) begin
                            start_cmd(d, m_pcmd[d]);
                            m_pvld[d] = one;
                            m_pcmd[d] = typ;
                        end else if (one) begin
                            start_cmd(d, typ);
                        end else begin
                            m_active[d] = 1'b0;
                        end
                    end else if (one) begin
                        ovr       = m_pvld[d];
                        m_pvld[d] = 1'b1;
                        m_pcmd[d] = typ;
                    end
                end else if (one) begin
                    start_cmd(d, typ);
                end
                sr = 1'b0; en = 1'b0; bsy = 1'b0;
                if (m_active[d]) begin
                    o2  = ncyc + 1 - m_start[d];
                    sr  = (o2 <= PW + 1);
                    en  = (o2 >= 1) && (o2 <= PW);
                    bsy = 1'b1;
                end
                v = {sr && !m_cmd[d], sr && m_cmd[d], en, bsy, dn, se && ce, ovr};
            end
            if (d == 0) exp_q0.push_back(v);
            else        exp_q1.push_back(v);
        end
        m_pset = rst ? 1'b1 : set_req;
        m_pclr = rst ? 1'b1 : clr_req;
    endtask

    task automatic monitor_step();
        logic [6:0] act, exp;
        bit have;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                act  = {bus0.S, bus0.R, bus0.Enable, bus0.busy, bus0.done,
                        bus0.err_conflict, bus0.overrun};
                have = (exp_q0.size() != 0);
                exp  = have ? exp_q0.pop_front() : 'x;
            end else begin
                act  = {bus1.S, bus1.R, bus1.Enable, bus1.busy, bus1.done,
                        bus1.err_conflict, bus1.overrun};
                have = (exp_q1.size() != 0);
                exp  = have ? exp_q1.pop_front() : 'x;
            end
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL dut%0d no_expectation cyc %0d: got %b, nothing queued",
                         d, ncyc, act);
            end else if (act !== exp) begin
                errors++;
                $display("FAIL dut%0d outputs cyc %0d: got %b want %b (S R En busy done err ovr)",
                         d, ncyc, act, exp);
            end
            checks++;
            if (act[6] && act[5]) begin
                errors++;
                $display("FAIL dut%0d s_and_r cyc %0d: got S=1 R=1 want not both", d, ncyc);
            end
            checks++;
            if (act[4] && (act[6] == act[5])) begin
                errors++;
                $display("FAIL dut%0d enable_onehot cyc %0d: got S=%b R=%b want exactly one",
                         d, ncyc, act[6], act[5]);
            end
            if (m_prev_en[d] && act[4]) begin
                checks++;
                if (act[6:5] != m_prev_sr[d]) begin
                    errors++;
                    $display("FAIL dut%0d sr_stable cyc %0d: got SR=%b want %b",
                             d, ncyc, act[6:5], m_prev_sr[d]);
                end
            end
            m_prev_en[d] = act[4];
            m_prev_sr[d] = act[6:5];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);
        // Single SET command.
        set_req = 1'b1; step(1); set_req = 1'b0; step(12);
        // RESET requested mid-PULSE is buffered and follows.
        set_req = 1'b1; step(1); set_req = 1'b0; step(2);
        clr_req = 1'b1; step(1); clr_req = 1'b0; step(20);
        // Simultaneous edges in IDLE.
        set_req = 1'b1; clr_req = 1'b1; step(1);
        set_req = 1'b0; clr_req = 1'b0; step(5);
        // Second busy-time request overwrites the slot.
        set_req = 1'b1; step(1); set_req = 1'b0; step(1);
        clr_req = 1'b1; step(1); clr_req = 1'b0; step(2);
        clr_req = 1'b1; step(1); clr_req = 1'b0; step(20);
        // Reset mid-PULSE with set held high; must re-arm before firing.
        set_req = 1'b1; step(3);
        rst = 1'b1; step(1); rst = 1'b0; step(15);
        set_req = 1'b0; step(1); set_req = 1'b1; step(1); set_req = 1'b0; step(15);
        // Random request levels with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) set_req = ~set_req;
            if ($urandom_range(0, 3) == 0) clr_req = ~clr_req;
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0; set_req = 1'b0; clr_req = 1'b0;
        step(20);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
